// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and digit-code helper for the display scheduler.
package display_pkg;
  localparam int SEG_DASH    = 16;
  localparam int SEG_BLANK   = 17;
  localparam int MAX_DISP    = 9999;
  localparam int CONV_CYCLES = 14;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  // A digit is blanked when it and every digit above it are zero.
  function automatic logic [4:0] digit_code(input logic [15:0] bcd, input logic dash,
                                            input logic [1:0] idx, input logic blank_lz);
    logic [15:0] upper;
    upper = bcd >> {idx, 2'b00};
    if (dash)
      return 5'(SEG_DASH);
    else if (blank_lz && (idx != 2'd0) && (upper == 16'd0))
      return 5'(SEG_BLANK);
    else
      return {1'b0, upper[3:0]};
  endfunction
endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: 14-bit binary to 4 BCD nibbles, one shift per cycle.
module bcd_converter
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);
  logic [29:0] sr;
  logic [3:0]  cnt;
  logic        run;
  logic [15:0] adj;

  always_comb begin
    adj = sr[29:14];
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = (sr[14+4*i +: 4] >= 4'd5) ? sr[14+4*i +: 4] + 4'd3 : sr[14+4*i +: 4];
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign done = run && (cnt == 4'(CONV_CYCLES-1));
  assign bcd  = sr[29:14];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sr  <= {16'd0, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr  <= {adj[14:0], sr[13:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/display_scheduler.sv
// Load/convert/commit FSM feeding double-buffered display registers, plus the 4-digit scan.
module display_scheduler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] big_bin,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  AN,
  output logic [4:0]  seven_in
);
  localparam int PW = $clog2(REFRESH_DIV);

  state_t        state, state_nxt;
  logic          in_range, start, commit, conv_done, ovf_cap;
  logic [15:0]   conv_bcd, disp_bcd, disp_bcd_nxt;
  logic          disp_dash, disp_dash_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    idx, idx_nxt;

  assign in_range = (big_bin <= 20'(MAX_DISP));
  assign start    = (state == S_IDLE) && load && in_range;
  assign busy     = (state != S_IDLE);
  assign ovf      = disp_dash;

  bcd_converter u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (big_bin[13:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    unique case (state)
      S_IDLE:    if (load) state_nxt = in_range ? S_CONVERT : S_COMMIT;
      S_CONVERT: if (conv_done) state_nxt = S_COMMIT;
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ovf_cap <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && load) ovf_cap <= !in_range;
    end
  end

  always_comb begin
    disp_bcd_nxt  = disp_bcd;
    disp_dash_nxt = disp_dash;
    if (commit) begin
      disp_bcd_nxt  = ovf_cap ? 16'h0 : conv_bcd;
      disp_dash_nxt = ovf_cap;
    end
  end

  assign tick    = (presc == PW'(REFRESH_DIV-1));
  assign idx_nxt = tick ? idx + 2'd1 : idx;

  // Scan outputs look at next-state display values so a same-edge commit shows at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      idx       <= 2'd0;
      disp_bcd  <= 16'h0;
      disp_dash <= 1'b0;
      AN        <= 4'b1110;
      seven_in  <= 5'd0;
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      idx       <= idx_nxt;
      disp_bcd  <= disp_bcd_nxt;
      disp_dash <= disp_dash_nxt;
      AN        <= ~(4'b0001 << idx_nxt);
      seven_in  <= digit_code(disp_bcd_nxt, disp_dash_nxt, idx_nxt, BLANK_LZ);
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler against a value-level reference model.
module tb_display_scheduler;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [19:0] big_bin;
  logic        busy1, ovf1, busy0, ovf0;
  logic [3:0]  an1, an0;
  logic [4:0]  seg1, seg0;

  int checks = 0;
  int passed = 0;

  display_scheduler #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .big_bin(big_bin), .load(load),
    .busy(busy1), .ovf(ovf1), .AN(an1), .seven_in(seg1));

  display_scheduler #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .big_bin(big_bin), .load(load),
    .busy(busy0), .ovf(ovf0), .AN(an0), .seven_in(seg0));

  always #5 clk = ~clk;

  // Reference model: cycles since reset, busy countdown, displayed value.
  int m_cyc, m_left, m_pend, m_disp;
  bit m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc <= 0; m_left <= 0; m_pend <= 0; m_disp <= 0; m_ovf <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_left == 0) begin
        if (load) begin
          m_pend <= int'(big_bin);
          m_left <= (big_bin > 20'd9999) ? 1 : 15;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ovf  <= (m_pend > 9999);
          m_disp <= (m_pend > 9999) ? 0 : m_pend;
        end
      end
    end
  end

  // Expected {busy, ovf, AN, seven_in}
  function automatic logic [10:0] expv(input bit blank);
    int i, p, code;
    i = (m_cyc / DIV) % 4;
    p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
    if (m_ovf)                           code = 16;
    else if (blank && i > 0 && m_disp < p) code = 17;
    else                                 code = (m_disp / p) % 10;
    return {m_left != 0, m_ovf, ~(4'b0001 << i), 5'(code)};
  endfunction

  task automatic test_reset;
    rst = 1'b0; load = 1'b0; big_bin = 20'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, ovf1, an1, seg1} !== 11'b0_0_1110_00000 || {busy0, ovf0, an0, seg0} !== 11'b0_0_1110_00000)
      $display("FAIL reset got=%h/%h exp=%h", {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, 11'b0_0_1110_00000);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_scan;
    logic [3:0] an_seen [8];
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      checks++;
      if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
        $display("FAIL scan c=%0d got=%h/%h exp=%h/%h", c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
      else passed++;
      if (c % 4 == 3) an_seen[c/4] = an1;
    end
    checks++;
    if ({an_seen[0], an_seen[1], an_seen[2], an_seen[3], an_seen[4]} !== 20'b1101_1011_0111_1110_1101)
      $display("FAIL scan_order got=%b exp=%b", {an_seen[0], an_seen[1], an_seen[2], an_seen[3], an_seen[4]}, 20'b1101_1011_0111_1110_1101);
    else passed++;
  endtask

  task automatic test_load(input logic [19:0] v, input int exp_busy, input logic [19:0] exp_digits, input string nm);
    int nb = 0;
    logic [4:0] d [4];
    load = 1'b1; big_bin = v;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
        $display("FAIL %s c=%0d got=%h/%h exp=%h/%h", nm, c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
      else passed++;
      if (busy1) nb++;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (an1 == ~(4'b0001 << k)) d[k] = seg1;
    end
    checks++;
    if (nb !== exp_busy) $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, nb, exp_busy);
    else passed++;
    checks++;
    if ({d[3], d[2], d[1], d[0]} !== exp_digits)
      $display("FAIL %s_digits got=%h exp=%h", nm, {d[3], d[2], d[1], d[0]}, exp_digits);
    else passed++;
  endtask

  task automatic test_overflow;
    test_load(20'd10000, 1, {5'd16, 5'd16, 5'd16, 5'd16}, "ovf");
    checks++;
    if (ovf1 !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", ovf1);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] d [4];
    load = 1'b1; big_bin = 20'h00057;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = (c == 4);
      if (c == 4) big_bin = 20'd500;
      checks++;
      if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
        $display("FAIL drop c=%0d got=%h/%h exp=%h/%h", c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
      else passed++;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (an1 == ~(4'b0001 << k)) d[k] = seg1;
    end
    checks++;
    if ({d[3], d[2], d[1], d[0]} !== {5'd17, 5'd17, 5'd8, 5'd7})
      $display("FAIL drop_digits got=%h exp=%h", {d[3], d[2], d[1], d[0]}, {5'd17, 5'd17, 5'd8, 5'd7});
    else passed++;
  endtask

  task automatic test_no_blank;
    int vals [3] = '{5, 9999, 0};
    logic [19:0] exps [3] = '{{5'd0, 5'd0, 5'd0, 5'd5}, {5'd9, 5'd9, 5'd9, 5'd9}, {5'd0, 5'd0, 5'd0, 5'd0}};
    logic [4:0] d [4];
    for (int n = 0; n < 3; n++) begin
      load = 1'b1; big_bin = 20'(vals[n]);
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
          $display("FAIL noblank c=%0d got=%h/%h exp=%h/%h", c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
        else passed++;
      end
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) if (an0 == ~(4'b0001 << k)) d[k] = seg0;
      end
      checks++;
      if ({d[3], d[2], d[1], d[0]} !== exps[n])
        $display("FAIL noblank_digits v=%0d got=%h exp=%h", vals[n], {d[3], d[2], d[1], d[0]}, exps[n]);
      else passed++;
    end
  endtask

  task automatic test_reset_abort;
    logic [4:0] d [4];
    load = 1'b1; big_bin = 20'd9999;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      load = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy1, ovf1, an1, seg1} !== 11'b0_0_1110_00000 || {busy0, ovf0, an0, seg0} !== 11'b0_0_1110_00000)
      $display("FAIL abort_reset got=%h/%h exp=%h", {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, 11'b0_0_1110_00000);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
        $display("FAIL abort c=%0d got=%h/%h exp=%h/%h", c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
      else passed++;
      for (int k = 0; k < 4; k++) if (an1 == ~(4'b0001 << k)) d[k] = seg1;
    end
    checks++;
    if ({busy1, d[3], d[2], d[1], d[0]} !== {1'b0, 5'd17, 5'd17, 5'd17, 5'd0})
      $display("FAIL abort_display got=%h exp=%h", {busy1, d[3], d[2], d[1], d[0]}, {1'b0, 5'd17, 5'd17, 5'd17, 5'd0});
    else passed++;
  endtask

  task automatic test_random;
    int hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({busy1, ovf1, an1, seg1} !== expv(1'b1) || {busy0, ovf0, an0, seg0} !== expv(1'b0))
        $display("FAIL random c=%0d got=%h/%h exp=%h/%h", c, {busy1, ovf1, an1, seg1}, {busy0, ovf0, an0, seg0}, expv(1'b1), expv(1'b0));
      else passed++;
      if (hold > 0) begin
        hold--;
        load = 1'b1;
      end else begin
        load = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 199) == 0) hold = int'($urandom_range(20, 60));
      end
      case ($urandom_range(0, 3))
        0:       big_bin = 20'($urandom_range(0, 9999));
        1:       big_bin = 20'($urandom);
        2:       big_bin = ($urandom_range(0, 1) == 0) ? 20'd9999 : 20'd10000;
        default: big_bin = 20'($urandom_range(0, 99));
      endcase
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_load(20'd1234, 15, {5'd1, 5'd2, 5'd3, 5'd4}, "load1234");
    test_overflow;
    test_back_to_back;
    test_no_blank;
    test_reset_abort;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
